// File: rtl/pwm_comparador_multicanal_if.sv
// Load bus for pwm_comparador_multicanal: requested period/thresholds
// and load strobe from the register side, load acknowledge back.
// Ports (signals):
//   periodo   - requested period (terminal count)
//   umbrales  - requested thresholds, channel i at [i*WIDTH +: WIDTH]
//   cargar    - load request, samples periodo/umbrales into shadow
//   carga_ack - one-cycle pulse when the shadow values became active
interface pwm_comparador_multicanal_if #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2
);
    logic [WIDTH-1:0]          periodo;
    logic [CHANNELS*WIDTH-1:0] umbrales;
    logic                      cargar;
    logic                      carga_ack;

    modport master (
        output periodo,
        output umbrales,
        output cargar,
        input  carga_ack
    );

    modport slave (
        input  periodo,
        input  umbrales,
        input  cargar,
        output carga_ack
    );
endinterface

// File: rtl/pwm_comparador_multicanal.sv
// Multi-channel compare/PWM unit with own period counter and shadowed
// period/threshold registers that take effect at a period boundary.
// Ports:
//   clock, reset_n - clock, asynchronous active-low reset
//   enable         - counter run enable
//   carga          - load bus (periodo, umbrales, cargar, carga_ack)
//   contador       - current counter value
//   salida_pwm     - per-channel PWM level (C < T_i), registered
//   coincidencia   - per-channel match pulse (C == T_i), registered
//   fin_periodo    - period-boundary pulse, registered
// Build option: PWM_UPDOWN_EN selects center-aligned up/down counting.
module pwm_comparador_multicanal #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    pwm_comparador_multicanal_if.slave carga,
    output logic [WIDTH-1:0]          contador,
    output logic [CHANNELS-1:0]       salida_pwm,
    output logic [CHANNELS-1:0]       coincidencia,
    output logic                      fin_periodo
);

    logic [WIDTH-1:0]          sombra_periodo;
    logic [WIDTH-1:0]          periodo_act;
    logic [CHANNELS*WIDTH-1:0] sombra_umbrales;
    logic [CHANNELS*WIDTH-1:0] umbrales_act;
    logic                      pendiente;
    logic                      frontera;
    logic                      transferir;
    logic [WIDTH-1:0]          cuenta_sig;
    logic [CHANNELS-1:0]       pwm_sig;
    logic [CHANNELS-1:0]       coin_sig;

`ifdef PWM_UPDOWN_EN
    // Direction is parked at "down" while stopped so the first 0 after
    // enable counts as a boundary.
    logic bajando;
    logic bajando_sig;

    always_comb begin
        frontera    = (periodo_act == '0) || (bajando && contador == '0);
        cuenta_sig  = '0;
        bajando_sig = 1'b1;
        if (enable && periodo_act != '0) begin
            if (bajando) begin
                if (contador == '0) begin
                    cuenta_sig  = WIDTH'(1);
                    bajando_sig = 1'b0;
                end else begin
                    cuenta_sig  = contador - WIDTH'(1);
                    bajando_sig = 1'b1;
                end
            end else if (contador >= periodo_act) begin
                cuenta_sig  = periodo_act - WIDTH'(1);
                bajando_sig = 1'b1;
            end else begin
                cuenta_sig  = contador + WIDTH'(1);
                bajando_sig = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bajando <= 1'b1;
        end else begin
            bajando <= bajando_sig;
        end
    end
`else
    always_comb begin
        frontera   = (contador == periodo_act);
        cuenta_sig = '0;
        if (enable && !frontera) begin
            cuenta_sig = contador + WIDTH'(1);
        end
    end
`endif

    // Only a load pending before this edge may transfer; a cargar at the
    // same edge stays in the shadow for the next boundary.
    assign transferir = pendiente && (!enable || frontera);

    always_comb begin
        pwm_sig  = '0;
        coin_sig = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_sig[i]  = contador <  umbrales_act[i*WIDTH +: WIDTH];
            coin_sig[i] = contador == umbrales_act[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sombra_periodo  <= '0;
            sombra_umbrales <= '0;
            periodo_act     <= '0;
            umbrales_act    <= '0;
            pendiente       <= 1'b0;
            carga.carga_ack <= 1'b0;
            contador        <= '0;
            salida_pwm      <= '0;
            coincidencia    <= '0;
            fin_periodo     <= 1'b0;
        end else begin
            if (carga.cargar) begin
                sombra_periodo  <= carga.periodo;
                sombra_umbrales <= carga.umbrales;
            end
            pendiente <= carga.cargar | (pendiente & ~transferir);
            if (transferir) begin
                periodo_act  <= sombra_periodo;
                umbrales_act <= sombra_umbrales;
            end
            carga.carga_ack <= transferir;
            contador        <= cuenta_sig;
            salida_pwm      <= enable ? pwm_sig  : '0;
            coincidencia    <= enable ? coin_sig : '0;
            fin_periodo     <= enable & frontera;
        end
    end

endmodule

// File: tb/tb_pwm_comparador_multicanal.sv
// Directed testbench for pwm_comparador_multicanal.
// Runs the up-mode tests, or the center-aligned test under PWM_UPDOWN_EN.
module tb_pwm_comparador_multicanal;
    localparam int W  = 12;
    localparam int CH = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [W-1:0]  contador;
    logic [CH-1:0] salida_pwm;
    logic [CH-1:0] coincidencia;
    logic          fin_periodo;

    int errors = 0;
    int checks = 0;

    pwm_comparador_multicanal_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    pwm_comparador_multicanal #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .carga        (bus.slave),
        .contador     (contador),
        .salida_pwm   (salida_pwm),
        .coincidencia (coincidencia),
        .fin_periodo  (fin_periodo)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put_load(input logic [W-1:0] p, input logic [W-1:0] t0,
                            input logic [W-1:0] t1);
        bus.periodo  = p;
        bus.umbrales = {t1, t0};
        bus.cargar   = 1'b1;
        step();
        bus.cargar   = 1'b0;
    endtask

    task automatic wait_ack(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.carga_ack) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b1;
        enable       = 1'b0;
        bus.cargar   = 1'b0;
        bus.periodo  = '0;
        bus.umbrales = '0;
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if ({contador, salida_pwm, coincidencia, fin_periodo, bus.carga_ack} !== '0)
            begin
            errors++;
            $display("FAIL reset_outputs: got c=%0d pwm=%b coin=%b fin=%b ack=%b want all 0",
                     contador, salida_pwm, coincidencia, fin_periodo, bus.carga_ack);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step();
        enable = 1'b1;
        step();
        step();
        step();
        checks++;
        if (contador !== 0 || fin_periodo !== 1'b1 || salida_pwm !== 2'b00 ||
            coincidencia !== 2'b11) begin
            errors++;
            $display("FAIL reset_p0_run: got c=%0d fin=%b pwm=%b coin=%b want 0 1 00 11",
                     contador, fin_periodo, salida_pwm, coincidencia);
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_load_disabled();
        put_load(12'd9, 12'd3, 12'd7);
        checks++;
        if (bus.carga_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_early: got %b want 0", bus.carga_ack);
        end
        step();
        checks++;
        if (bus.carga_ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_two_edges: got %b want 1", bus.carga_ack);
        end
        step();
        checks++;
        if (bus.carga_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_one_cycle: got %b want 0", bus.carga_ack);
        end
    endtask

    task automatic test_duty();
        int n_p0, n_p1, n_c0, n_fin, c, pc;
        logic [CH-1:0] e_pwm, e_coin;
        n_p0 = 0; n_p1 = 0; n_c0 = 0; n_fin = 0;
        enable = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            c  = k % 10;
            pc = (k - 1) % 10;
            e_pwm  = {pc < 7, pc < 3};
            e_coin = {pc == 7, pc == 3};
            checks++;
            if (contador !== W'(c) || salida_pwm !== e_pwm ||
                coincidencia !== e_coin || fin_periodo !== (pc == 9)) begin
                errors++;
                $display("FAIL duty_cycle%0d: got c=%0d pwm=%b coin=%b fin=%b want %0d %b %b %b",
                         k, contador, salida_pwm, coincidencia, fin_periodo,
                         c, e_pwm, e_coin, pc == 9);
            end
            n_p0  += int'(salida_pwm[0]);
            n_p1  += int'(salida_pwm[1]);
            n_c0  += int'(coincidencia[0]);
            n_fin += int'(fin_periodo);
        end
        checks++;
        if (n_p0 != 6 || n_p1 != 14 || n_c0 != 2 || n_fin != 2) begin
            errors++;
            $display("FAIL duty_counts: got p0=%0d p1=%0d c0=%0d fin=%0d want 6 14 2 2",
                     n_p0, n_p1, n_c0, n_fin);
        end
    endtask

    task automatic test_midload();
        bit seen;
        int n_p0, n_c0;
        for (int k = 0; k < 20 && contador != 4; k++) step();
        checks++;
        if (contador !== 4) begin
            errors++;
            $display("FAIL midload_reach4: got %0d want 4", contador);
        end
        put_load(12'd9, 12'd5, 12'd7);
        checks++;
        if (salida_pwm[0] !== 1'b0) begin
            errors++;
            $display("FAIL midload_old_t0: got pwm0=%b want 0", salida_pwm[0]);
        end
        wait_ack(seen);
        checks++;
        if (!seen || contador !== 0) begin
            errors++;
            $display("FAIL midload_ack: got seen=%0d c=%0d want 1 0", seen, contador);
        end
        n_p0 = 0; n_c0 = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_p0 += int'(salida_pwm[0]);
            n_c0 += int'(coincidencia[0]);
        end
        checks++;
        if (n_p0 != 5 || n_c0 != 1) begin
            errors++;
            $display("FAIL midload_new_t0: got high=%0d match=%0d want 5 1", n_p0, n_c0);
        end
    endtask

    task automatic test_limits();
        bit seen;
        int n_p0, n_p1, n_c0, n_c1, n_fin;
        bit bad_c;
        put_load(12'd9, 12'd0, 12'd4095);
        wait_ack(seen);
        n_p0 = 0; n_p1 = 0; n_c0 = 0; n_c1 = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_p0 += int'(salida_pwm[0]);
            n_p1 += int'(salida_pwm[1]);
            n_c0 += int'(coincidencia[0]);
            n_c1 += int'(coincidencia[1]);
        end
        checks++;
        if (!seen || n_p0 != 0 || n_p1 != 10 || n_c0 != 1 || n_c1 != 0) begin
            errors++;
            $display("FAIL limits_t0_t1: got ack=%0d p0=%0d p1=%0d c0=%0d c1=%0d want 1 0 10 1 0",
                     seen, n_p0, n_p1, n_c0, n_c1);
        end
        put_load(12'd0, 12'd0, 12'd0);
        wait_ack(seen);
        n_fin = 0; bad_c = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_fin += int'(fin_periodo);
            if (contador != 0) bad_c = 1'b1;
        end
        checks++;
        if (!seen || n_fin != 5 || bad_c) begin
            errors++;
            $display("FAIL limits_p0: got ack=%0d fin=%0d cnz=%0d want 1 5 0",
                     seen, n_fin, bad_c);
        end
    endtask

    task automatic test_double_load();
        bit seen;
        int acks, n_p0;
        put_load(12'd9, 12'd3, 12'd7);
        wait_ack(seen);
        for (int k = 0; k < 20 && contador != 2; k++) step();
        put_load(12'd9, 12'd2, 12'd7);
        put_load(12'd9, 12'd6, 12'd7);
        wait_ack(seen);
        acks = int'(seen);
        n_p0 = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_p0 += int'(salida_pwm[0]);
            acks += int'(bus.carga_ack);
        end
        checks++;
        if (acks != 1 || n_p0 != 6) begin
            errors++;
            $display("FAIL double_load: got acks=%0d high=%0d want 1 6", acks, n_p0);
        end
    endtask

    task automatic test_reset_midcount();
        bit bad;
        step();
        step();
        put_load(12'd4, 12'd1, 12'd1);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({contador, salida_pwm, coincidencia, fin_periodo, bus.carga_ack} !== '0)
            begin
            errors++;
            $display("FAIL reset_async: got c=%0d pwm=%b coin=%b fin=%b ack=%b want all 0",
                     contador, salida_pwm, coincidencia, fin_periodo, bus.carga_ack);
        end
        @(negedge clock);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (contador != 0 || bus.carga_ack || salida_pwm != 0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_discard: got stray activity after reset want none");
        end
    endtask

`ifdef PWM_UPDOWN_EN
    task automatic test_updown();
        int exp_c [16] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0};
        int n_p0, n_p1, n_c0, n_fin;
        put_load(12'd4, 12'd2, 12'd9);
        step();
        enable = 1'b1;
        n_p0 = 0; n_p1 = 0; n_c0 = 0; n_fin = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (contador !== W'(exp_c[k])) begin
                errors++;
                $display("FAIL updown_seq%0d: got %0d want %0d", k, contador, exp_c[k]);
            end
            n_p0  += int'(salida_pwm[0]);
            n_p1  += int'(salida_pwm[1]);
            n_c0  += int'(coincidencia[0]);
            n_fin += int'(fin_periodo);
        end
        checks++;
        if (n_p0 != 6 || n_p1 != 16 || n_c0 != 4 || n_fin != 2) begin
            errors++;
            $display("FAIL updown_counts: got p0=%0d p1=%0d c0=%0d fin=%0d want 6 16 4 2",
                     n_p0, n_p1, n_c0, n_fin);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PWM_UPDOWN_EN
        test_updown();
`else
        test_load_disabled();
        test_duty();
        test_midload();
        test_limits();
        test_double_load();
        test_reset_midcount();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
